mem_sync_rw: RTL and testbench



---
 rtl/mem_sync_rw.sv | 111 +++++++++++
 tb/tb_mem_sync_rw.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sync_rw.sv
// rtl/mem_sync_rw.sv - clocked word memory with request/response handshake, byte enables and self-clearing init
module mem_sync_rw #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 10,
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  init_done
);

    localparam int NB       = DATA_W / 8;
    localparam int CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT_W    = 4;
    localparam int LAT_LAST = (READ_LAT > 1) ? READ_LAT - 2 : 0;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_init_cnt;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic                r_resp_err;
    logic                r_init_done;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic                w_in_range;
    logic                w_init_last;
    logic [CNT_W-1:0]    w_idx;

    // Full-width compare so high address bits can never alias into the array.
    assign w_in_range  = (req_addr < ADDR_W'(DEPTH));
    assign w_idx       = req_addr[CNT_W-1:0];
    assign w_accept    = (r_state == ST_IDLE) && req_valid;
    assign w_init_last = (r_init_cnt == CNT_W'(DEPTH - 1));

    assign req_ready   = (r_state == ST_IDLE);
    assign resp_valid  = (r_state == ST_RESP);
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    assign init_done   = r_init_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_init_last) w_state_nxt = ST_IDLE;
            ST_IDLE: if (req_valid) w_state_nxt = (READ_LAT == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_lat_cnt == LAT_W'(LAT_LAST)) w_state_nxt = ST_RESP;
            ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_INIT;
            r_init_cnt   <= '0;
            r_lat_cnt    <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_init_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
                if (w_init_last) r_init_done <= 1'b1;
            end
            if (w_accept) begin
                r_lat_cnt    <= '0;
                r_resp_rdata <= (!req_we && w_in_range) ? r_mem[w_idx] : '0;
                r_resp_err   <= !w_in_range;
            end else if (r_state == ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end
            if ((r_state == ST_RESP) && resp_ready) begin
                r_resp_rdata <= '0;
                r_resp_err   <= 1'b0;
            end
        end
    end

    // Array has no reset; the INIT sweep clears it after every reset release.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_accept && req_we && w_in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (req_be[k]) r_mem[w_idx][8*k +: 8] <= req_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_sync_rw.sv
// tb/tb_mem_sync_rw.sv - scoreboard bench for mem_sync_rw at read latencies 1, 3 and 4
module tb_mem_sync_rw;

    localparam int NI = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n      [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_we     [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic [3:0]  req_be     [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err   [NI];
    logic        init_done  [NI];

    logic [31:0] model [NI][10];
    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_sync_rw #(
            .DATA_W  (32),
            .DEPTH   (10),
            .ADDR_W  (32),
            .READ_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g]),
            .init_done (init_done[g])
        );
    end

    function automatic int lat_of(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 3 : 4);
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e.rdata = 32'hxxxx_xxxx;
        e.err   = 1'bx;
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    // Model update and scoreboard push happen when the request is committed.
    task automatic push_exp(input int idx, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        e.err   = (addr >= 32'd10);
        e.rdata = (!we && !e.err) ? model[idx][addr] : 32'h0;
        if (we && !e.err) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) model[idx][addr][8*k +: 8] = wdata[8*k +: 8];
            end
        end
        sb.push_back(e);
    endtask

    task automatic send(input int idx, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold,
                        output int lat, output logic [31:0] got_rdata, output logic got_err,
                        output bit stable, output bit post_ok);
        int n;
        lat = -1; got_rdata = 'x; got_err = 'x; stable = 1'b0; post_ok = 1'b0;
        @(negedge clk);
        req_valid[idx] = 1'b1; req_we[idx] = we; req_addr[idx] = addr;
        req_wdata[idx] = wdata; req_be[idx] = be; resp_ready[idx] = 1'b0;
        n = 0;
        while (req_ready[idx] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (req_ready[idx] !== 1'b1) begin
            req_valid[idx] = 1'b0;
            return;
        end
        push_exp(idx, we, addr, wdata, be);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        n = 1;
        while (resp_valid[idx] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (resp_valid[idx] !== 1'b1) return;
        lat = n; got_rdata = resp_rdata[idx]; got_err = resp_err[idx];
        stable = (req_ready[idx] === 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (resp_valid[idx] !== 1'b1 || resp_rdata[idx] !== got_rdata ||
                resp_err[idx] !== got_err || req_ready[idx] !== 1'b0) stable = 1'b0;
        end
        resp_ready[idx] = 1'b1;
        @(negedge clk);
        resp_ready[idx] = 1'b0;
        post_ok = (resp_valid[idx] === 1'b0) && (req_ready[idx] === 1'b1) &&
                  (resp_rdata[idx] === 32'h0) && (resp_err[idx] === 1'b0);
    endtask

    task automatic test_reset();
        int lat; logic [31:0] rd; logic er; bit st, po; exp_t e;
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0; req_be[i] = '0; resp_ready[i] = 1'b0;
            for (int a = 0; a < 10; a++) model[i][a] = 32'h0;
        end
        repeat (3) @(negedge clk);
        total++;
        if ({req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0], init_done[0]} !== 36'h0) begin
            bad++;
            $display("FAIL reset_values: got rdy=%b vld=%b rd=%h err=%b done=%b want all 0",
                     req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0], init_done[0]);
        end
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            total++;
            if ({req_ready[0], init_done[0]} !== 2'b00) begin
                bad++;
                $display("FAIL init_cycle_%0d: got rdy/done=%b%b want 00", c, req_ready[0], init_done[0]);
            end
            @(negedge clk);
        end
        total++;
        if ({req_ready[0], init_done[0]} !== 2'b11) begin
            bad++;
            $display("FAIL init_cycle_11: got rdy/done=%b%b want 11", req_ready[0], init_done[0]);
        end
        send(0, 1'b0, 32'd9, 32'h0, 4'h0, 0, lat, rd, er, st, po);
        e = pop_exp();
        total++;
        if (rd !== 32'h0 || er !== 1'b0 || rd !== e.rdata || er !== e.err) begin
            bad++;
            $display("FAIL init_read9: got rd=%h err=%b want rd=00000000 err=0", rd, er);
        end
    endtask

    task automatic test_basic_lat1();
        int lat; logic [31:0] rd; logic er; bit st, po; exp_t e;
        send(0, 1'b1, 32'd0, 32'hA00000AA, 4'hF, 0, lat, rd, er, st, po);
        e = pop_exp();
        total++;
        if (lat !== 1 || rd !== e.rdata || er !== e.err || !po) begin
            bad++;
            $display("FAIL lat1_write: got lat=%0d rd=%h err=%b post=%b want lat=1 rd=%h err=%b post=1",
                     lat, rd, er, po, e.rdata, e.err);
        end
        send(0, 1'b0, 32'd0, 32'h0, 4'h0, 0, lat, rd, er, st, po);
        e = pop_exp();
        total++;
        if (lat !== 1 || rd !== 32'hA00000AA || rd !== e.rdata || er !== 1'b0) begin
            bad++;
            $display("FAIL lat1_read: got lat=%0d rd=%h err=%b want lat=1 rd=a00000aa err=0", lat, rd, er);
        end
    endtask

    task automatic test_byte_enable();
        int lat; logic [31:0] rd; logic er; bit st, po; exp_t e;
        send(0, 1'b1, 32'd3, 32'h11223344, 4'hF, 0, lat, rd, er, st, po);
        e = pop_exp();
        send(0, 1'b1, 32'd3, 32'hFFFFFFFF, 4'b0010, 0, lat, rd, er, st, po);
        e = pop_exp();
        send(0, 1'b0, 32'd3, 32'h0, 4'h0, 0, lat, rd, er, st, po);
        e = pop_exp();
        total++;
        if (rd !== 32'h1122FF44 || rd !== e.rdata || er !== 1'b0) begin
            bad++;
            $display("FAIL byte_enable: got rd=%h err=%b want rd=1122ff44 err=0", rd, er);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic er; bit st, po; exp_t e;
        send(0, 1'b0, 32'd10, 32'h0, 4'h0, 0, lat, rd, er, st, po);
        e = pop_exp();
        total++;
        if (rd !== 32'h0 || er !== 1'b1 || lat !== 1 || !po) begin
            bad++;
            $display("FAIL oor_read10: got rd=%h err=%b lat=%0d post=%b want rd=0 err=1 lat=1 post=1", rd, er, lat, po);
        end
        send(0, 1'b1, 32'd5, 32'h12345678, 4'hF, 0, lat, rd, er, st, po);
        e = pop_exp();
        send(0, 1'b1, 32'h8000_0005, 32'hDEADBEEF, 4'hF, 0, lat, rd, er, st, po);
        e = pop_exp();
        total++;
        if (er !== 1'b1 || rd !== 32'h0 || er !== e.err) begin
            bad++;
            $display("FAIL oor_write_hi: got rd=%h err=%b want rd=0 err=1", rd, er);
        end
        send(0, 1'b1, 32'd5, 32'hFFFFFFFF, 4'h0, 0, lat, rd, er, st, po);
        e = pop_exp();
        total++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("FAIL be0_write_resp: got lat=%0d rd=%h err=%b want lat=1 rd=0 err=0", lat, rd, er);
        end
        send(0, 1'b0, 32'd5, 32'h0, 4'h0, 0, lat, rd, er, st, po);
        e = pop_exp();
        total++;
        if (rd !== 32'h12345678 || rd !== e.rdata || er !== 1'b0) begin
            bad++;
            $display("FAIL oor_no_alias: got rd=%h err=%b want rd=12345678 err=0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic er; bit st, po; exp_t e;
        send(1, 1'b1, 32'd1, 32'hCAFEF00D, 4'hF, 0, lat, rd, er, st, po);
        e = pop_exp();
        total++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("FAIL lat3_write: got lat=%0d rd=%h err=%b want lat=3 rd=0 err=0", lat, rd, er);
        end
        send(1, 1'b0, 32'd1, 32'h0, 4'h0, 4, lat, rd, er, st, po);
        e = pop_exp();
        total++;
        if (lat !== 3 || rd !== 32'hCAFEF00D || rd !== e.rdata || er !== 1'b0) begin
            bad++;
            $display("FAIL bp_read: got lat=%0d rd=%h err=%b want lat=3 rd=cafef00d err=0", lat, rd, er);
        end
        total++;
        if (!st) begin
            bad++;
            $display("FAIL bp_stable: got stable=%b want 1", st);
        end
        total++;
        if (!po) begin
            bad++;
            $display("FAIL bp_after_handshake: got post=%b want 1 (ready=1 valid=0 outputs cleared)", po);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er; bit st, po; exp_t e;
        bit we; logic [31:0] addr, wd; logic [3:0] be;
        for (int i = 0; i < 12; i++) begin
            we   = (i < 4) ? 1'b1 : $urandom_range(0, 1);
            addr = $urandom_range(0, 11);
            wd   = $urandom;
            be   = $urandom_range(0, 15);
            send(1, we, addr, wd, be, i % 3, lat, rd, er, st, po);
            e = pop_exp();
            total++;
            if (lat !== 3 || rd !== e.rdata || er !== e.err || !st || !po) begin
                bad++;
                $display("FAIL b2b_%0d: got lat=%0d rd=%h err=%b st=%b post=%b want lat=3 rd=%h err=%b st=1 post=1",
                         i, lat, rd, er, st, po, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er; bit st, po; exp_t e; bit seen; int n;
        send(2, 1'b1, 32'd2, 32'h55, 4'hF, 0, lat, rd, er, st, po);
        e = pop_exp();
        total++;
        if (lat !== 4 || er !== 1'b0) begin
            bad++;
            $display("FAIL lat4_write: got lat=%0d err=%b want lat=4 err=0", lat, er);
        end
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'd2; resp_ready[2] = 1'b1;
        n = 0;
        while (req_ready[2] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid[2] = 1'b0;
        seen = (resp_valid[2] === 1'b1);
        @(negedge clk);
        seen |= (resp_valid[2] === 1'b1);
        rst_n[2] = 1'b0;
        #1;
        total++;
        if ({resp_valid[2], req_ready[2], init_done[2], resp_err[2]} !== 4'b0 || resp_rdata[2] !== 32'h0) begin
            bad++;
            $display("FAIL midreset_async: got vld=%b rdy=%b done=%b err=%b rd=%h want all 0",
                     resp_valid[2], req_ready[2], init_done[2], resp_err[2], resp_rdata[2]);
        end
        repeat (2) @(negedge clk);
        for (int a = 0; a < 10; a++) model[2][a] = 32'h0;
        rst_n[2] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            seen |= (resp_valid[2] === 1'b1) || (req_ready[2] === 1'b1);
            @(negedge clk);
        end
        resp_ready[2] = 1'b0;
        total++;
        if (seen || req_ready[2] !== 1'b1 || init_done[2] !== 1'b1) begin
            bad++;
            $display("FAIL midreset_discard: got seen=%b rdy=%b done=%b want seen=0 rdy=1 done=1",
                     seen, req_ready[2], init_done[2]);
        end
        send(2, 1'b0, 32'd2, 32'h0, 4'h0, 0, lat, rd, er, st, po);
        e = pop_exp();
        total++;
        if (lat !== 4 || rd !== 32'h0 || rd !== e.rdata || er !== 1'b0) begin
            bad++;
            $display("FAIL midreset_read2: got lat=%0d rd=%h err=%b want lat=4 rd=0 err=0", lat, rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_basic_lat1();
        test_byte_enable();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
